// File: rtl/lbus_pkg.sv
// Shared definitions for the local-bus memory target.
// Holds the cmd_i field layout, the transaction command payload, the FSM
// state encoding and the burst-length decode helpers.
package lbus_pkg;

  // cmd_i field positions
  localparam int unsigned CMD_W      = 7;
  localparam int unsigned CMD_WR     = 0;
  localparam int unsigned CMD_LEN_LO = 1;
  localparam int unsigned CMD_LEN_HI = 2;
  localparam int unsigned CMD_BE_LO  = 3;
  localparam int unsigned CMD_BE_HI  = 6;

  // Beat counter (bursts up to 8) and wait-state counter (0..15) widths
  localparam int unsigned BEAT_W = 3;
  localparam int unsigned WCNT_W = 4;

  // Latched transaction command
  typedef struct packed {
    logic [3:0] be;
    logic [1:0] len;
    logic       wr;
  } lbus_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DATA = 2'd2
  } lbus_state_e;

  // Number of beats L = 2^code
  function automatic logic [3:0] burst_len(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

  // Index of the final beat, L-1; doubles as the wrap mask
  function automatic logic [BEAT_W-1:0] last_beat(input logic [1:0] code);
    return BEAT_W'(burst_len(code) - 4'd1);
  endfunction

endpackage

// File: rtl/lbus_wrap_addr.sv
// Wrapping burst address generator.
// Word index of beat k: the burst stays inside the L-aligned block holding
// the start word and wraps around its end.
//   start    : start word index of the burst
//   beat     : beat number k (0..L-1)
//   len_code : log2 of burst length L
//   idx_c    : word index for this beat (combinational)
module lbus_wrap_addr
  import lbus_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic [IDX_W-1:0]  start,
  input  logic [BEAT_W-1:0] beat,
  input  logic [1:0]        len_code,
  output logic [IDX_W-1:0]  idx_c
);

  logic [IDX_W-1:0] mask;
  logic [IDX_W-1:0] sum;

  // Upper bits come from the start word, low bits wrap modulo L
  always_comb begin
    mask  = IDX_W'(last_beat(len_code));
    sum   = start + IDX_W'(beat);
    idx_c = (start & ~mask) | (sum & mask);
  end

endmodule

// File: rtl/lbus_mem_target.sv
// Local-bus memory target.
// Claims transactions whose address falls in a 2^ADDR_BITS byte window at
// BASE and serves single-word and wrapping burst reads/writes from an
// on-chip word array, with programmable initial and inter-beat wait states.
//   BUSCLK  : bus clock
//   ResetN  : synchronous active-low reset
//   frame_i : address phase strobe; addr_i/cmd_i valid with it
//   addr_i  : byte address
//   cmd_i   : [0] write, [2:1] log2 beats, [6:3] byte enables
//   irdy_i  : master ready (write data valid / read data taken)
//   abort_i : master terminates the transaction
//   wdata_i : write data
//   sel_o   : target has claimed the transaction
//   trdy_o  : target ready for the current beat
//   rdata_o : read data, valid while trdy_o is high on reads
//   busy_o  : target is not idle
module lbus_mem_target
  import lbus_pkg::*;
#(
  parameter logic [31:0]  BASE        = 32'h1FC0_0000,
  parameter int unsigned  ADDR_BITS   = 12,
  parameter int unsigned  WAIT_STATES = 2,
  parameter int unsigned  BURST_WAIT  = 0
) (
  input  logic              BUSCLK,
  input  logic              ResetN,
  input  logic              frame_i,
  input  logic [31:0]       addr_i,
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic              irdy_i,
  input  logic              abort_i,
  input  logic [31:0]       wdata_i,
  output logic              sel_o,
  output logic              trdy_o,
  output logic [31:0]       rdata_o,
  output logic              busy_o
);

  localparam int unsigned IDX_W = ADDR_BITS - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;

  lbus_state_e       state, state_n;
  logic [WCNT_W-1:0] wcnt, wcnt_n;
  logic [BEAT_W-1:0] beat, beat_n;
  logic [IDX_W-1:0]  start, start_n;
  lbus_cmd_t         cmd, cmd_n;

  logic              hit;
  logic              last;
  logic              beat_done;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_n;
  logic              unused_addr;

  logic [31:0]       mem [DEPTH];

  // Byte offset bits carry no meaning for a word array
  assign unused_addr = ^addr_i[1:0];

  assign hit  = frame_i && (addr_i[31:ADDR_BITS] == BASE[31:ADDR_BITS]);
  assign last = (beat == last_beat(cmd.len));

  // Word index of the beat in progress (write target)
  lbus_wrap_addr #(.IDX_W(IDX_W)) u_wrap_cur (
    .start    (start),
    .beat     (beat),
    .len_code (cmd.len),
    .idx_c    (idx)
  );

  // Word index of the beat presented after this edge (read data preload)
  lbus_wrap_addr #(.IDX_W(IDX_W)) u_wrap_nxt (
    .start    (start_n),
    .beat     (beat_n),
    .len_code (cmd_n.len),
    .idx_c    (idx_n)
  );

  // Next-state logic; abort outranks beat completion
  always_comb begin
    state_n   = state;
    wcnt_n    = wcnt;
    beat_n    = beat;
    start_n   = start;
    cmd_n     = cmd;
    beat_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          start_n    = addr_i[ADDR_BITS-1:2];
          cmd_n.wr   = cmd_i[CMD_WR];
          cmd_n.len  = cmd_i[CMD_LEN_HI:CMD_LEN_LO];
          cmd_n.be   = cmd_i[CMD_BE_HI:CMD_BE_LO];
          beat_n     = '0;
          if (WAIT_STATES > 0) begin
            state_n = WAIT;
            wcnt_n  = WCNT_W'(WAIT_STATES - 1);
          end else begin
            state_n = DATA;
          end
        end
      end
      WAIT: begin
        if (abort_i) begin
          state_n = IDLE;
        end else if (wcnt == '0) begin
          state_n = DATA;
        end else begin
          wcnt_n = wcnt - WCNT_W'(1);
        end
      end
      DATA: begin
        if (abort_i) begin
          state_n = IDLE;
        end else if (irdy_i) begin
          beat_done = 1'b1;
          if (last) begin
            state_n = IDLE;
          end else begin
            beat_n = beat + BEAT_W'(1);
            if (BURST_WAIT > 0) begin
              state_n = WAIT;
              wcnt_n  = WCNT_W'(BURST_WAIT - 1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and registered bus outputs
  always_ff @(posedge BUSCLK) begin
    if (!ResetN) begin
      state   <= IDLE;
      wcnt    <= '0;
      beat    <= '0;
      start   <= '0;
      cmd     <= '0;
      sel_o   <= 1'b0;
      trdy_o  <= 1'b0;
      busy_o  <= 1'b0;
      rdata_o <= '0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      beat    <= beat_n;
      start   <= start_n;
      cmd     <= cmd_n;
      sel_o   <= (state_n != IDLE);
      trdy_o  <= (state_n == DATA);
      busy_o  <= (state_n != IDLE);
      // Reloading every DATA cycle keeps a stalled beat's word on the bus
      if (state_n == DATA) begin
        rdata_o <= mem[idx_n];
      end
    end
  end

  // Word array: byte-lane writes on completed write beats, never cleared
  always_ff @(posedge BUSCLK) begin
    if (ResetN && beat_done && cmd.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (cmd.be[b]) begin
          mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_lbus_mem_target.sv
// Self-checking bench for lbus_mem_target: directed bring-up sequences plus
// randomized transactions against a word-array reference model.
module tb_lbus_mem_target;

  localparam logic [31:0] BASE   = 32'h1FC0_0000;
  localparam int          WS     = 2;
  localparam int          BW     = 1;
  localparam int          DEPTH  = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0;
  logic [31:0] addr = '0;
  logic [6:0]  cmd = '0;
  logic        irdy = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] wdata = '0;
  logic        sel, trdy, busy;
  logic [31:0] rdata;

  lbus_mem_target #(
    .BASE        (BASE),
    .ADDR_BITS   (12),
    .WAIT_STATES (WS),
    .BURST_WAIT  (BW)
  ) dut (
    .BUSCLK  (clk),
    .ResetN  (rst_n),
    .frame_i (frame),
    .addr_i  (addr),
    .cmd_i   (cmd),
    .irdy_i  (irdy),
    .abort_i (abort),
    .wdata_i (wdata),
    .sel_o   (sel),
    .trdy_o  (trdy),
    .rdata_o (rdata),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wq [$];
  logic [31:0] rq [$];
  logic [31:0] last_rd = '0;
  int          irdy_pct = 100;
  int          vectors = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word visited by beat k of an L-beat burst starting at word s
  function automatic int beat_word(input int s, input int k, input int len);
    return (s / len) * len + (s + k) % len;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_trdy"}, 32'(trdy), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One bus transaction, checked cycle by cycle.
  // stop_at: loop cycle at which to abort (or reset if stop_rst); -1 = none.
  task automatic txn(input logic [31:0] a, input bit wr, input int lc,
                     input logic [3:0] be, input int stop_at, input bit stop_rst);
    int          len, s, gap, k, n, w;
    bit          hit, done, stopped;
    logic [31:0] wd, obs;
    len = 1 << lc;
    s = int'(a[11:2]);
    hit = (a[31:12] == BASE[31:12]);
    gap = WS; k = 0; n = 0; done = 0; stopped = 0;
    rq.delete();
    frame = 1'b1; addr = a; cmd = {be, 2'(lc), wr}; abort = 1'b0;
    irdy = 1'($urandom_range(1)); wdata = $urandom;
    @(negedge clk);
    frame = 1'b0;
    if (!hit) begin
      for (int i = 0; i < 2; i++) begin
        check_idle("miss");
        abort = 1'($urandom_range(1));
        @(negedge clk);
      end
      abort = 1'b0;
      return;
    end
    while (!done) begin
      if (n > 200) begin
        check("timeout", 32'd1, 32'd0);
        break;
      end
      check("sel", 32'(sel), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("trdy", 32'(trdy), 32'(gap == 0));
      w = beat_word(s, k, len);
      obs = rdata;
      if (!wr && gap == 0) begin
        check("rdata", rdata, ref_mem[w]);
        last_rd = ref_mem[w];
      end else if (!wr && k > 0) begin
        check("rd_hold", rdata, last_rd);
      end
      irdy  = ($urandom_range(99) < 32'(irdy_pct));
      wd    = (wq.size() > 0) ? wq[0] : $urandom;
      wdata = wd;
      // Stray address phases while busy must be ignored
      frame = ($urandom_range(7) == 0);
      addr  = BASE | ($urandom & 32'hFFF);
      cmd   = 7'($urandom);
      abort = (n == stop_at) && !stop_rst;
      rst_n = !((n == stop_at) && stop_rst);
      @(negedge clk);
      if (n == stop_at) begin
        done = 1; stopped = 1;
      end else if (gap > 0) begin
        gap--;
      end else if (irdy) begin
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
          if (wq.size() > 0) void'(wq.pop_front());
        end else begin
          rq.push_back(obs);
        end
        k++;
        if (k == len) done = 1;
        else gap = BW;
      end
      n++;
    end
    frame = 1'b0; abort = 1'b0; rst_n = 1'b1; irdy = 1'b0;
    check_idle("end");
    if (stopped && stop_rst) check("rst_rdata", rdata, 32'd0);
    else if (!wr && k > 0) check("idle_hold", rdata, last_rd);
    wq.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          st;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill the whole array with full-word 8-beat bursts
    for (int i = 0; i < DEPTH / 8; i++) txn(BASE + 32'(i * 32), 1'b1, 3, 4'hF, -1, 1'b0);

    // Single read of a preloaded word; timing checked inside txn
    wq.push_back(32'hDEADBEEF);
    txn(BASE + 32'h40, 1'b1, 0, 4'hF, -1, 1'b0);
    txn(BASE + 32'h40, 1'b0, 0, 4'hF, -1, 1'b0);
    check("t1_cnt", 32'(rq.size()), 32'd1);
    if (rq.size() == 1) check("t1_data", rq[0], 32'hDEADBEEF);

    // Wrapping 4-beat write from word 2, read back in the same order
    for (int i = 1; i <= 4; i++) wq.push_back(32'(i));
    txn(BASE + 32'h08, 1'b1, 2, 4'hF, -1, 1'b0);
    txn(BASE + 32'h08, 1'b0, 2, 4'hF, -1, 1'b0);
    check("t2_cnt", 32'(rq.size()), 32'd4);
    for (int i = 0; i < 4 && i < rq.size(); i++) check("t2_data", rq[i], 32'(i + 1));
    txn(BASE + 32'h00, 1'b0, 0, 4'hF, -1, 1'b0);
    if (rq.size() == 1) check("t2_word0", rq[0], 32'd3);

    // Byte-lane merge
    wq.push_back(32'h11223344);
    txn(BASE, 1'b1, 0, 4'hF, -1, 1'b0);
    wq.push_back(32'hAABBCCDD);
    txn(BASE, 1'b1, 0, 4'b0010, -1, 1'b0);
    txn(BASE, 1'b0, 0, 4'hF, -1, 1'b0);
    if (rq.size() == 1) check("t3_merge", rq[0], 32'h1122CC44);
    else check("t3_cnt", 32'(rq.size()), 32'd1);

    // 8-beat reads with master stalls
    irdy_pct = 50;
    for (int i = 0; i < 4; i++) begin
      txn(BASE + 32'h100 + 32'(i * 12), 1'b0, 3, 4'hF, -1, 1'b0);
      check("t4_beats", 32'(rq.size()), 32'd8);
    end
    irdy_pct = 100;

    // Outside the window
    txn(BASE + 32'h1000, 1'b0, 0, 4'hF, -1, 1'b0);
    txn(BASE - 32'h4, 1'b1, 2, 4'hF, -1, 1'b0);

    // Abort on beat 2 (loop cycle 6 with WS=2, BW=1), then reset on beat 2
    for (int i = 0; i < 4; i++) wq.push_back(32'hA0 + 32'(i));
    txn(BASE + 32'h20, 1'b1, 2, 4'hF, -1, 1'b0);
    for (int i = 0; i < 4; i++) wq.push_back(32'hB0 + 32'(i));
    txn(BASE + 32'h20, 1'b1, 2, 4'hF, 6, 1'b0);
    txn(BASE + 32'h20, 1'b0, 2, 4'hF, -1, 1'b0);
    if (rq.size() == 4) begin
      check("t6_abort0", rq[0], 32'hB0); check("t6_abort1", rq[1], 32'hB1);
      check("t6_abort2", rq[2], 32'hA2); check("t6_abort3", rq[3], 32'hA3);
    end else check("t6_cnt", 32'(rq.size()), 32'd4);
    for (int i = 0; i < 4; i++) wq.push_back(32'hC0 + 32'(i));
    txn(BASE + 32'h20, 1'b1, 2, 4'hF, 6, 1'b1);
    txn(BASE + 32'h20, 1'b0, 2, 4'hF, -1, 1'b0);
    if (rq.size() == 4) begin
      check("t6_rst0", rq[0], 32'hC0); check("t6_rst1", rq[1], 32'hC1);
      check("t6_rst2", rq[2], 32'hA2); check("t6_rst3", rq[3], 32'hA3);
    end else check("t6_cnt2", 32'(rq.size()), 32'd4);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      a = BASE | ($urandom & 32'hFFF);
      if ($urandom_range(9) == 0) a = a ^ (32'd1 << $urandom_range(31, 12));
      st = ($urandom_range(9) == 0) ? int'($urandom_range(20)) : -1;
      irdy_pct = int'($urandom_range(100, 50));
      txn(a, 1'($urandom_range(1)), int'($urandom_range(3)), 4'($urandom),
          st, ($urandom_range(2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
